spine_router: RTL

Spine-level switch for the leaf/spine GPU fabric. Each leaf router's spine-facing output lands on one input port here, and each output port drives that leaf router's spine input. Flits are buffered per input, routed by destination group, and arbitrated round-robin per output. Leaf routers hold their spine-side ready high, so this block never back-pressures: it accepts every valid flit, or drops it and counts the drop.

---
 rtl/spine_router.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spine_router.sv
// Spine switch: four input FIFOs feed four outputs selected by dest group, with per-output
// round-robin arbitration and a registered output stage. Never back-pressures; drops are counted.
module spine_router #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SPINE_ID   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DWIDTH-1:0]   leaf_in_data,
  input  logic [3:0]            leaf_in_valid,
  input  logic [23:0]           leaf_in_dest_addr,
  output logic [4*DWIDTH-1:0]   leaf_out_data,
  output logic [3:0]            leaf_out_valid,
  output logic [23:0]           leaf_out_dest_addr,
  output logic [3:0]            fifo_full,
  output logic [3:0]            fifo_empty,
  output logic [7:0]            drop_count,
  output logic [11:0]           current_grant
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = DWIDTH + 6;

  // Status-only identifier; kept visible for integration but has no functional effect.
  logic [31:0] spine_id_unused;
  assign spine_id_unused = 32'(SPINE_ID);

  logic [EW-1:0] mem_q [4][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q [4], wr_ptr_d [4];
  logic [PW-1:0] rd_ptr_q [4], rd_ptr_d [4];
  logic [CW-1:0] cnt_q [4], cnt_d [4];
  logic [1:0]    rr_q [4], rr_d [4];

  logic [4*DWIDTH-1:0] out_data_q, out_data_d;
  logic [23:0]         out_dest_q, out_dest_d;
  logic [3:0]          out_valid_q, out_valid_d;
  logic [11:0]         grant_q, grant_d;
  logic [7:0]          drop_count_q, drop_count_d;

  logic [EW-1:0] head [4];
  logic [3:0]    grp [4];
  logic [3:0]    nonempty, bad, pop, push, in_drop;
  logic [3:0]    req [4];
  logic [3:0]    gnt_vld;
  logic [1:0]    gnt_idx [4];
  logic [3:0]    drop_sum;
  logic [8:0]    drop_ext;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      head[i]     = mem_q[i][rd_ptr_q[i]];
      grp[i]      = head[i][EW-1 -: 4];
      nonempty[i] = (cnt_q[i] != '0);
      // Out-of-range groups are discarded from the head in one cycle.
      bad[i]      = nonempty[i] && (grp[i] > 4'd3);
    end
  end

  always_comb begin
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 4; i++) begin
        req[o][i] = nonempty[i] && (grp[i] == 4'(o));
      end
    end
  end

  always_comb begin
    logic [1:0] idx;
    idx = '0;
    for (int o = 0; o < 4; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = 2'd0;
      rr_d[o]    = rr_q[o];
      for (int k = 0; k < 4; k++) begin
        idx = rr_q[o] + 2'(k);
        if (!gnt_vld[o] && req[o][idx]) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = idx;
        end
      end
      if (gnt_vld[o]) rr_d[o] = gnt_idx[o] + 2'd1;
    end
  end

  always_comb begin
    logic full_i;
    full_i   = 1'b0;
    drop_sum = '0;
    for (int i = 0; i < 4; i++) begin
      pop[i] = bad[i];
      for (int o = 0; o < 4; o++) begin
        if (gnt_vld[o] && (gnt_idx[o] == 2'(i))) pop[i] = 1'b1;
      end
      full_i      = (cnt_q[i] == CW'(FIFO_DEPTH));
      // A pop frees the slot in the same cycle, so a full FIFO still accepts.
      push[i]     = leaf_in_valid[i] && (!full_i || pop[i]);
      in_drop[i]  = leaf_in_valid[i] && full_i && !pop[i];
      wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
      cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      drop_sum    = drop_sum + 4'(in_drop[i]) + 4'(bad[i]);
    end
    drop_ext     = {1'b0, drop_count_q} + 9'(drop_sum);
    drop_count_d = drop_ext[8] ? 8'hFF : drop_ext[7:0];
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_dest_d  = out_dest_q;
    out_valid_d = gnt_vld;
    grant_d     = '0;
    for (int o = 0; o < 4; o++) begin
      if (gnt_vld[o]) begin
        out_data_d[o*DWIDTH +: DWIDTH] = head[gnt_idx[o]][DWIDTH-1:0];
        out_dest_d[o*6 +: 6]           = head[gnt_idx[o]][EW-1 -: 6];
        grant_d[o*3 +: 3]              = {1'b1, gnt_idx[o]};
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {leaf_in_dest_addr[i*6 +: 6], leaf_in_data[i*DWIDTH +: DWIDTH]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '{default: '0};
      rd_ptr_q     <= '{default: '0};
      cnt_q        <= '{default: '0};
      rr_q         <= '{default: '0};
      out_data_q   <= '0;
      out_dest_q   <= '0;
      out_valid_q  <= '0;
      grant_q      <= '0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      out_data_q   <= out_data_d;
      out_dest_q   <= out_dest_d;
      out_valid_q  <= out_valid_d;
      grant_q      <= grant_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fifo_full[i]  = (cnt_q[i] == CW'(FIFO_DEPTH));
      fifo_empty[i] = (cnt_q[i] == '0);
    end
  end

  assign leaf_out_data      = out_data_q;
  assign leaf_out_dest_addr = out_dest_q;
  assign leaf_out_valid     = out_valid_q;
  assign current_grant      = grant_q;
  assign drop_count         = drop_count_q;

endmodule
